board_renderer: RTL and testbench

// Consumer side of the game-logic block interface. Holds the settled-block board (a 4-bit

---
 rtl/board_renderer_if.sv | 28 ++
 rtl/board_renderer.sv | 179 +++++++++++++++++
 tb/tb_board_renderer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_renderer_if.sv
// Game-logic <-> board renderer link: lock handshake, board commands and live-block position.
interface board_renderer_if;
  logic       lock_valid;
  logic [5:0] lock_x;
  logic [6:0] lock_y;
  logic [3:0] lock_color;
  logic       lock_ready;
  logic       clear_req;
  logic       shift_req;
  logic [6:0] shift_row;
  logic [5:0] piece_x;
  logic [6:0] piece_y;
  logic [3:0] piece_color;

  modport master (
    output lock_valid, lock_x, lock_y, lock_color,
    input  lock_ready,
    output clear_req, shift_req, shift_row,
    output piece_x, piece_y, piece_color
  );

  modport slave (
    input  lock_valid, lock_x, lock_y, lock_color,
    output lock_ready,
    input  clear_req, shift_req, shift_row,
    input  piece_x, piece_y, piece_color
  );
endinterface

// File: rtl/board_renderer.sv
// Settled-block board storage with lock/clear/row-collapse sequencing and a two-stage
// beam-to-palette-index pipeline (board + live block + border frame).
//
// state   | meaning
// S_IDLE  | accepting locks; clear/shift requests start a sequence
// S_CLEAR | zeroing row cur_q, one row per cycle, top to bottom
// S_SHIFT | copying row cur_q-1 into row cur_q, walking up; row 0 zeroed last
module board_renderer #(
  parameter int         COLS       = 12,
  parameter int         ROWS       = 19,
  parameter int         CELL_SHIFT = 4,
  parameter int         ORIGIN_X   = 224,
  parameter int         ORIGIN_Y   = 48,
  parameter logic [3:0] BORDER_IDX = 4'hF
) (
  input  logic               Clk,
  input  logic               Reset,
  board_renderer_if.slave    gi,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [3:0]         pixel_idx,
  output logic [ROWS-1:0]    row_full,
  output logic               busy
);

  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int CELL = 1 << CELL_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT} state_t;
  typedef enum logic [1:0] {R_OUTSIDE, R_BORDER, R_BOARD} region_t;

  state_t        state_q, state_d;
  logic [RW-1:0] cur_q, cur_d;
  logic [3:0]    cells [ROWS][COLS];
  logic          lock_we;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      busy    <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    unique case (state_q)
      S_IDLE: begin
        if (gi.clear_req) begin
          state_d = S_CLEAR;
          cur_d   = '0;
        end else if (gi.shift_req && (gi.shift_row < 7'(ROWS))) begin
          state_d = S_SHIFT;
          cur_d   = gi.shift_row[RW-1:0];
        end
      end
      S_CLEAR: begin
        if (cur_q == RW'(ROWS-1)) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end else begin
          cur_d = cur_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cur_q == '0) state_d = S_IDLE;
        else             cur_d   = cur_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gi.lock_ready = (state_q == S_IDLE) & ~gi.clear_req & ~gi.shift_req;
  // out-of-range coordinates are still handshaken so the requester never stalls
  assign lock_we = gi.lock_valid & gi.lock_ready &
                   (gi.lock_x < 6'(COLS)) & (gi.lock_y < 7'(ROWS));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells[r][c] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (lock_we) cells[gi.lock_y[RW-1:0]][gi.lock_x[CW-1:0]] <= gi.lock_color;
        S_CLEAR:
          for (int c = 0; c < COLS; c++) cells[cur_q][c] <= '0;
        S_SHIFT: begin
          if (cur_q == '0) begin
            for (int c = 0; c < COLS; c++) cells[0][c] <= '0;
          end else begin
            for (int c = 0; c < COLS; c++) cells[cur_q][c] <= cells[cur_q - 1'b1][c];
          end
        end
        default: ;
      endcase
    end
  end

  logic [ROWS-1:0] full_d;

  always_comb begin
    full_d = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (cells[r][c] == 4'h0) full_d[r] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) row_full <= '0;
    else       row_full <= full_d;
  end

  // Offsetting the beam by one cell puts the frame ring at cell index 0 and COLS+1,
  // so a single unsigned compare covers both the border and the board.
  logic [10:0] ex, ey, fx, fy;
  logic        in_x, in_y, frame_x, frame_y, board_x, board_y;
  region_t     region_d;

  always_comb begin
    ex       = {1'b0, DrawX} + 11'(CELL);
    ey       = {1'b0, DrawY} + 11'(CELL);
    in_x     = (ex >= 11'(ORIGIN_X));
    in_y     = (ey >= 11'(ORIGIN_Y));
    fx       = (ex - 11'(ORIGIN_X)) >> CELL_SHIFT;
    fy       = (ey - 11'(ORIGIN_Y)) >> CELL_SHIFT;
    frame_x  = in_x && (fx <= 11'(COLS + 1));
    frame_y  = in_y && (fy <= 11'(ROWS + 1));
    board_x  = in_x && (fx != '0) && (fx <= 11'(COLS));
    board_y  = in_y && (fy != '0) && (fy <= 11'(ROWS));
    region_d = R_OUTSIDE;
    if (board_x && board_y)      region_d = R_BOARD;
    else if (frame_x && frame_y) region_d = R_BORDER;
  end

  region_t       region_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [5:0]    px_q;
  logic [6:0]    py_q;
  logic [3:0]    pc_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      region_q  <= R_OUTSIDE;
      col_q     <= '0;
      row_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      pc_q      <= '0;
      pixel_idx <= '0;
    end else begin
      region_q <= region_d;
      col_q    <= CW'(fx - 11'd1);
      row_q    <= RW'(fy - 11'd1);
      px_q     <= gi.piece_x;
      py_q     <= gi.piece_y;
      pc_q     <= gi.piece_color;
      unique case (region_q)
        R_BORDER: pixel_idx <= BORDER_IDX;
        R_BOARD: begin
          if ((pc_q != 4'h0) && (px_q == 6'(col_q)) && (py_q == 7'(row_q)))
            pixel_idx <= pc_q;
          else
            pixel_idx <= cells[row_q][col_q];
        end
        default: pixel_idx <= 4'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Randomized self-checking bench for board_renderer against an array-based board model.
module tb_board_renderer;
  localparam int COLS = 12;
  localparam int ROWS = 19;
  localparam int OX   = 224;
  localparam int OY   = 48;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [3:0]  pixel_idx;
  logic [18:0] row_full;
  logic        busy;

  board_renderer_if bi ();

  board_renderer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .gi        (bi.slave),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .pixel_idx (pixel_idx),
    .row_full  (row_full),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int board_m [ROWS][COLS];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int exp_pix(int x, int y, int px, int py, int pc);
    int c, r;
    if (x >= OX && x < OX + COLS*16 && y >= OY && y < OY + ROWS*16) begin
      c = (x - OX) / 16;
      r = (y - OY) / 16;
      if (pc != 0 && px == c && py == r) return pc;
      return board_m[r][c];
    end
    if (x >= OX - 16 && x < OX + (COLS+1)*16 && y >= OY - 16 && y < OY + (ROWS+1)*16)
      return 15;
    return 0;
  endfunction

  function automatic int exp_rf();
    int v = 0;
    for (int r = 0; r < ROWS; r++) begin
      bit full = 1'b1;
      for (int c = 0; c < COLS; c++) if (board_m[r][c] == 0) full = 1'b0;
      if (full) v |= (1 << r);
    end
    return v;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) board_m[r][c] = 0;
  endtask

  task automatic pix_check(input string tag, input int x, input int y,
                           input int px, input int py, input int pc);
    DrawX = 10'(x);
    DrawY = 10'(y);
    bi.piece_x = 6'(px);
    bi.piece_y = 7'(py);
    bi.piece_color = 4'(pc);
    tick();
    tick();
    chk(tag, pixel_idx, exp_pix(x, y, px, py, pc));
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        pix_check(tag, OX + c*16 + 8, OY + r*16 + 8, 0, 0, 0);
  endtask

  task automatic do_lock(input int x, input int y, input int col);
    int guard = 0;
    bi.lock_x = 6'(x);
    bi.lock_y = 7'(y);
    bi.lock_color = 4'(col);
    bi.lock_valid = 1'b1;
    #1;
    while (!bi.lock_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      chk("lock_timeout", 0, 1);
    end else begin
      tick();
      if (x < COLS && y < ROWS) board_m[y][x] = col;
    end
    bi.lock_valid = 1'b0;
  endtask

  task automatic do_shift(input int row);
    int n = 0;
    bi.shift_row = 7'(row);
    bi.shift_req = 1'b1;
    tick();
    bi.shift_req = 1'b0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    chk("shift_busy_cycles", n, (row < ROWS) ? row + 1 : 0);
    if (row < ROWS) begin
      for (int r = row; r > 0; r--)
        for (int c = 0; c < COLS; c++) board_m[r][c] = board_m[r-1][c];
      for (int c = 0; c < COLS; c++) board_m[0][c] = 0;
    end
  endtask

  initial begin
    int n;
    bi.lock_valid = 0; bi.lock_x = 0; bi.lock_y = 0; bi.lock_color = 0;
    bi.clear_req = 0; bi.shift_req = 0; bi.shift_row = 0;
    bi.piece_x = 0; bi.piece_y = 0; bi.piece_color = 0;
    m_clear();
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    tick();
    chk("rst_pixel", pixel_idx, 0);
    chk("rst_row_full", row_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lock_ready", bi.lock_ready, 1);

    // exact two-cycle pixel latency after a lock
    do_lock(5, 17, 2);
    DrawX = 10'(OX + 5*16 + 3);
    DrawY = 10'(OY + 17*16 + 7);
    tick();
    chk("lat_one_clk", pixel_idx, 0);
    tick();
    chk("lat_two_clk", pixel_idx, 2);

    // full bottom row, then collapse it
    for (int c = 0; c < COLS; c++) do_lock(c, 18, 1);
    tick();
    chk("row18_full", row_full, exp_rf());
    chk("row18_full_bit", row_full[18], 1);
    do_lock(0, 17, 5);
    do_shift(18);
    tick();
    chk("after_shift_row_full", row_full, exp_rf());
    chk("after_shift_cell", exp_pix(OX + 8, OY + 18*16 + 8, 0, 0, 0), 5);
    sweep("after_shift_board");

    // piece overlay, border and outside
    do_lock(3, 2, 1);
    pix_check("piece_over", OX + 3*16 + 1, OY + 2*16 + 15, 3, 2, 7);
    pix_check("piece_none", OX + 3*16 + 1, OY + 2*16 + 15, 3, 2, 0);
    pix_check("border_left", OX - 8, OY + 5*16 + 4, 0, 0, 0);
    pix_check("outside_x0", 0, OY + 5*16 + 4, 0, 0, 0);
    pix_check("border_right", OX + COLS*16 + 3, OY + 40, 0, 0, 0);
    pix_check("border_bottom", OX + 40, OY + ROWS*16 + 15, 0, 0, 0);
    pix_check("outside_below", OX + 40, OY + (ROWS+1)*16, 0, 0, 0);

    // out-of-range requests
    do_shift(19);
    do_lock(12, 4, 9);
    do_lock(4, 19, 9);
    sweep("oob_board");

    // randomized mix against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: do_lock($urandom_range(0, 13), $urandom_range(0, 20), $urandom_range(0, 15));
        2: do_shift($urandom_range(0, 21));
        default: begin
          for (int k = 0; k < 6; k++) begin
            int x = $urandom_range(180, 460);
            int y = $urandom_range(0, 400);
            int px = $urandom_range(0, 12);
            int py = $urandom_range(0, 19);
            if ($urandom_range(0, 1) == 1 && x >= OX && y >= OY) begin
              px = (x - OX) / 16;
              py = (y - OY) / 16;
            end
            pix_check("rand_pixel", x, y, px, py, $urandom_range(0, 15));
          end
        end
      endcase
      tick();
      chk("rand_row_full", row_full, exp_rf());
    end
    sweep("rand_board");

    // clear beats a same-cycle lock
    bi.clear_req = 1'b1;
    bi.lock_valid = 1'b1;
    bi.lock_x = 1;
    bi.lock_y = 1;
    bi.lock_color = 6;
    #1;
    chk("clear_lock_ready", bi.lock_ready, 0);
    tick();
    bi.clear_req = 1'b0;
    bi.lock_valid = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    chk("clear_busy_cycles", n, ROWS);
    m_clear();
    tick();
    chk("clear_row_full", row_full, 0);
    sweep("clear_board");

    // reset in the middle of a shift over a full board
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) do_lock(c, r, 3);
    tick();
    chk("all_full", row_full, 19'h7FFFF);
    bi.shift_row = 18;
    bi.shift_req = 1'b1;
    tick();
    bi.shift_req = 1'b0;
    repeat (5) tick();
    chk("mid_shift_busy", busy, 1);
    Reset = 1'b1;
    #2;
    chk("async_rst_busy", busy, 0);
    m_clear();
    tick();
    Reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_row_full", row_full, 0);
    sweep("post_rst_board");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
